irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 128 ++++++++++++
 tb/tb_irq_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/mask/mode registers, a vector of the lowest active line, and a combined irq.
// Optional build macro IRQ_CTRL_SYNC_EN adds a 2-flop input synchronizer in front of the line sampling.
module irq_ctrl #(
   parameter int WIDTH = 32,  // must be >= 32 so VECTOR bit 31 exists
   parameter int NIRQ  = 32   // 1..32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              wen,
   input  logic [3:0]        addr,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   input  logic [NIRQ-1:0]   irq_in,
   output logic              irq
);

   typedef enum logic [3:0] {
      ADDR_PEND   = 4'd0,
      ADDR_MASK   = 4'd1,
      ADDR_MODE   = 4'd2,
      ADDR_VECTOR = 4'd3,
      ADDR_ACK    = 4'd4,
      ADDR_SWSET  = 4'd5,
      ADDR_RAW    = 4'd6
   } reg_addr_e;

   logic [NIRQ-1:0] irq_s;
   logic [NIRQ-1:0] prev_q;
   logic [NIRQ-1:0] pend_q, pend_d;
   logic [NIRQ-1:0] mask_q, mask_d;
   logic [NIRQ-1:0] mode_q, mode_d;
   logic [NIRQ-1:0] hw_set, sw_set, w1c_clr, ack_clr, active;
   logic            wr_en;
   logic            any_active;
   logic [4:0]      vec_idx;

`ifdef IRQ_CTRL_SYNC_EN
   logic [NIRQ-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_in;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = irq_in;
`endif

   assign wr_en = cs & wen;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
      hw_set  = irq_s & (mode_q | ~prev_q);
      sw_set  = '0;
      w1c_clr = '0;
      ack_clr = '0;
      mask_d  = mask_q;
      mode_d  = mode_q;

      if (wr_en) begin
         case (addr)
            ADDR_PEND:  w1c_clr = din[NIRQ-1:0];
            ADDR_MASK:  mask_d  = din[NIRQ-1:0];
            ADDR_MODE:  mode_d  = din[NIRQ-1:0];
            ADDR_SWSET: sw_set  = din[NIRQ-1:0];
            ADDR_ACK: begin
               // indices at or above NIRQ match no line and are dropped
               for (int i = 0; i < NIRQ; i++) begin
                  if (din[4:0] == 5'(i)) ack_clr[i] = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // sets are OR-ed after the clear so a same-cycle hardware set wins
      pend_d = (pend_q & ~(w1c_clr | ack_clr)) | sw_set | hw_set;
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         prev_q <= '0;
         pend_q <= '0;
         mask_q <= '0;
         mode_q <= '0;
      end else begin
         prev_q <= irq_s;
         pend_q <= pend_d;
         mask_q <= mask_d;
         mode_q <= mode_d;
      end
   end

   assign active     = pend_q & mask_q;
   assign any_active = |active;
   assign irq        = any_active;

   always_comb begin
      vec_idx = '0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (active[i]) vec_idx = 5'(i);
      end
   end

   always_comb begin
      dout = '0;
      case (addr)
         ADDR_PEND: dout[NIRQ-1:0] = pend_q;
         ADDR_MASK: dout[NIRQ-1:0] = mask_q;
         ADDR_MODE: dout[NIRQ-1:0] = mode_q;
         ADDR_RAW:  dout[NIRQ-1:0] = irq_s;
         ADDR_VECTOR: begin
            dout[31]  = any_active;
            dout[4:0] = vec_idx;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: expected register reads are queued as stimulus is driven and drained against dout/irq.
module tb_irq_ctrl;

   localparam int WIDTH = 32;
   localparam int NIRQ  = 32;
`ifdef IRQ_CTRL_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic              clk;
   logic              reset;
   logic              cs;
   logic              wen;
   logic [3:0]        addr;
   logic [WIDTH-1:0]  din;
   logic [WIDTH-1:0]  dout;
   logic [NIRQ-1:0]   irq_in;
   logic              irq;

   typedef struct {
      string       name;
      logic [3:0]  a;
      logic [31:0] dv;
      logic        iv;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   irq_ctrl #(.WIDTH(WIDTH), .NIRQ(NIRQ)) dut (
      .clk    (clk),
      .reset  (reset),
      .cs     (cs),
      .wen    (wen),
      .addr   (addr),
      .din    (din),
      .dout   (dout),
      .irq_in (irq_in),
      .irq    (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      cs   = 1'b1;
      wen  = 1'b1;
      addr = a;
      din  = d;
      tick();
      cs   = 1'b0;
      wen  = 1'b0;
      din  = '0;
   endtask

   task automatic push_exp(input string n, input logic [3:0] a, input logic [31:0] dv, input logic iv);
      sb_q.push_back('{n, a, dv, iv});
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      cs     = 1'b0;
      wen    = 1'b0;
      addr   = '0;
      din    = '0;
      irq_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();
      push_exp("rst_pend",   4'd0, 32'h0, 1'b0);
      push_exp("rst_mask",   4'd1, 32'h0, 1'b0);
      push_exp("rst_mode",   4'd2, 32'h0, 1'b0);
      push_exp("rst_vector", 4'd3, 32'h0, 1'b0);
      push_exp("rst_raw",    4'd6, 32'h0, 1'b0);
      push_exp("rst_unmap7", 4'd7, 32'h0, 1'b0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
   endtask

   task automatic test_mask_ack();
      wr(4'd1, 32'h5);
      irq_in[2] = 1'b1;
      tick();
      irq_in[2] = 1'b0;
      repeat (LAT) tick();
      push_exp("ack_pend",   4'd0, 32'h4,        1'b1);
      push_exp("ack_vector", 4'd3, 32'h80000002, 1'b1);
      push_exp("ack_mask",   4'd1, 32'h5,        1'b1);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      wr(4'd4, 32'd2);
      push_exp("ack_pend_clr", 4'd0, 32'h0, 1'b0);
      push_exp("ack_vec_clr",  4'd3, 32'h0, 1'b0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
   endtask

   task automatic test_latency();
      wr(4'd1, 32'h2);
      irq_in[1] = 1'b1;
      #1;
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL lat_before_edge: got irq=%b, want irq=0", irq);
      end
      for (int i = 0; i < LAT; i++) begin
         tick();
         n_checks++;
         if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_sync_stage%0d: got irq=%b, want irq=0", i, irq);
         end
      end
      tick();
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL lat_asserted: got irq=%b, want irq=1", irq);
      end
      irq_in[1] = 1'b0;
      repeat (LAT + 1) tick();
      wr(4'd0, 32'h2);
      push_exp("lat_pend_clr", 4'd0, 32'h0, 1'b0);
      push_exp("lat_raw_low",  4'd6, 32'h0, 1'b0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      wr(4'd1, 32'h0);
   endtask

   task automatic test_masked_pend();
      wr(4'd1, 32'h0);
      irq_in[7] = 1'b1;
      tick();
      irq_in[7] = 1'b0;
      repeat (LAT) tick();
      push_exp("mp_pend",   4'd0, 32'h80, 1'b0);
      push_exp("mp_vector", 4'd3, 32'h0,  1'b0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      wr(4'd1, 32'h80);
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL mp_unmask_irq: got irq=%b, want irq=1", irq);
      end
      push_exp("mp_vector7", 4'd3, 32'h80000007, 1'b1);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      wr(4'd0, 32'h80);
      wr(4'd1, 32'h0);
   endtask

   task automatic test_level_mode();
      wr(4'd2, 32'h1);
      wr(4'd1, 32'h1);
      irq_in[0] = 1'b1;
      repeat (LAT + 1) tick();
      push_exp("lvl_raw_high", 4'd6, 32'h1, 1'b1);
      push_exp("lvl_pend_set", 4'd0, 32'h1, 1'b1);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      wr(4'd0, 32'h1);
      push_exp("lvl_clr_held", 4'd0, 32'h1, 1'b1);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      irq_in[0] = 1'b0;
      repeat (LAT + 1) tick();
      wr(4'd0, 32'h1);
      push_exp("lvl_clr_released", 4'd0, 32'h0, 1'b0);
      push_exp("lvl_mode",         4'd2, 32'h1, 1'b0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      wr(4'd2, 32'h0);
      wr(4'd1, 32'h0);
   endtask

   task automatic test_set_wins();
      wr(4'd5, 32'h8);
      irq_in[3] = 1'b1;
      repeat (LAT) tick();
      wr(4'd0, 32'h8);
      push_exp("sw_set_wins", 4'd0, 32'h8, 1'b0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      wr(4'd0, 32'h8);
      push_exp("sw_steady_clr", 4'd0, 32'h0, 1'b0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      irq_in[3] = 1'b0;
      repeat (LAT + 1) tick();
   endtask

   task automatic test_regmap();
      wr(4'd5, 32'h0000F0F0);
      wr(4'd0, 32'h000000F0);
      cs   = 1'b0;
      wen  = 1'b1;
      addr = 4'd1;
      din  = 32'hFFFFFFFF;
      tick();
      wen  = 1'b0;
      din  = '0;
      push_exp("map_w1c_multi", 4'd0,  32'h0000F000, 1'b0);
      push_exp("map_no_cs",     4'd1,  32'h0,        1'b0);
      push_exp("map_ack_rd",    4'd4,  32'h0,        1'b0);
      push_exp("map_swset_rd",  4'd5,  32'h0,        1'b0);
      push_exp("map_unmap15",   4'd15, 32'h0,        1'b0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      wr(4'd1, 32'h80000000);
      wr(4'd5, 32'h80000000);
      push_exp("map_vector31", 4'd3, 32'h8000001F, 1'b1);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      wr(4'd1, 32'h80001000);
      push_exp("map_vector_lowest", 4'd3, 32'h8000000C, 1'b1);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      wr(4'd0, 32'hFFFFFFFF);
      wr(4'd1, 32'h0);
   endtask

   task automatic test_swset_reset();
      wr(4'd1, 32'h30);
      wr(4'd2, 32'h3);
      wr(4'd5, 32'h30);
      push_exp("swr_vector", 4'd3, 32'h80000004, 1'b1);
      push_exp("swr_mode",   4'd2, 32'h3,        1'b1);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL swr_async_irq: got irq=%b, want irq=0", irq);
      end
      push_exp("swr_rst_pend",   4'd0, 32'h0, 1'b0);
      push_exp("swr_rst_mask",   4'd1, 32'h0, 1'b0);
      push_exp("swr_rst_mode",   4'd2, 32'h0, 1'b0);
      push_exp("swr_rst_vector", 4'd3, 32'h0, 1'b0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      irq_in[5] = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      repeat (LAT + 1) tick();
      push_exp("swr_held_line_edge", 4'd0, 32'h20, 1'b0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         addr = e.a;
         #1;
         n_checks++;
         if (dout !== e.dv || irq !== e.iv) begin
            n_fail++;
            $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", e.name, dout, irq, e.dv, e.iv);
         end
      end
      irq_in[5] = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mask_ack();
      test_latency();
      test_masked_pend();
      test_level_mode();
      test_set_wins();
      test_regmap();
      test_swset_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
